// File: rtl/dcache_wb_buffer.sv
// ---------------------------------------------------------------------------
// dcache_wb_buffer
//
// Write-back drain buffer that sits between the data-cache controller and the
// memory-side write bus. Dirty 128-bit lines evicted by the controller are
// queued in a small circular FIFO. Each line is then drained as one 4-beat,
// 32-bit burst: an address phase, four data beats, and a write response.
// While a line is queued, its data can be looked up by address, so that a
// refill of that line is served from the buffer instead of from stale memory.
//
// Parameters
//   DEPTH   number of queued lines (power of two, 2 or 4)
//   ADDR_W  byte-address width
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-low reset
//   wb_valid/ready  controller-side push handshake; wb_ready = not full
//   wb_addr         line base address (bits [3:0] are dropped and stored as 0)
//   wb_data         line data, word0 in [31:0]
//   q_addr          lookup address, compared on bits [ADDR_W-1:4]
//   q_hit, q_data   combinational lookup result; the newest match wins,
//                   and q_data is 0 on a miss
//   aw_*            burst address channel (aw_len is always 3, i.e. 4 beats)
//   w_*             burst data channel, w_last marks beat 3
//   b_valid/ready   write response handshake; retires the head entry
//   empty           no queued lines (used for fence/uncached ordering)
// ---------------------------------------------------------------------------
module dcache_wb_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [127:0]      wb_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [127:0]      q_data,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data,
  output logic              w_last,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [PW:0]       wptr_q, wptr_d;
  logic [PW:0]       rptr_q, rptr_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [127:0]      data_q [DEPTH];
  logic [127:0]      data_d [DEPTH];

  logic [PW-1:0]     widx;
  logic [PW-1:0]     ridx;
  logic [PW-1:0]     lk_idx;
  logic              full;
  logic              push;
  logic              pop;
  logic [127:0]      head_data;
  logic              unused_bits;

  // The extra pointer bit tells full (same index, different lap) apart from
  // empty (identical pointers).
  assign widx  = wptr_q[PW-1:0];
  assign ridx  = rptr_q[PW-1:0];
  assign full  = (wptr_q[PW] != rptr_q[PW]) && (widx == ridx);
  assign empty = (wptr_q == rptr_q);

  // wb_ready depends only on registered pointers, so a push can never ride on
  // the same cycle's response to squeeze into a full buffer.
  assign wb_ready = ~full;
  assign push     = wb_valid & ~full;
  assign pop      = (state_q == S_B) & b_valid;

  // The byte offset within a line carries no information here.
  assign unused_bits = ^{wb_addr[3:0], q_addr[3:0]};

  // FIFO storage: a push fills the tail slot, a response retires the head.
  // Both may happen in one cycle; since push needs not-full and pop needs
  // not-empty, they always touch different slots.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push) begin
      addr_d[widx]  = {wb_addr[ADDR_W-1:4], 4'h0};
      data_d[widx]  = wb_data;
      valid_d[widx] = 1'b1;
      wptr_d        = wptr_q + PTR_ONE;
    end
    if (pop) begin
      valid_d[ridx] = 1'b0;
      rptr_d        = rptr_q + PTR_ONE;
    end
  end

  // Drain sequencer: address, four beats, response, then one idle cycle
  // before the next line's address goes out.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_AW;
        end
      end
      S_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) begin
          state_d = S_W;
        end
      end
      S_W: begin
        w_valid = 1'b1;
        if (w_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = S_B;
          end
        end
      end
      S_B: begin
        b_ready = 1'b1;
        if (b_valid) begin
          beat_d  = 2'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus payloads are forced to zero outside their phase; inside a phase they
  // come straight from the head slot and beat counter, which only move on a
  // handshake, so they hold steady under backpressure.
  assign head_data = data_q[ridx];
  assign aw_addr   = aw_valid ? addr_q[ridx] : '0;
  assign aw_len    = 8'd3;
  assign w_data    = w_valid ? head_data[{beat_q, 5'd0} +: 32] : 32'h0;
  assign w_last    = w_valid && (beat_q == 2'd3);

  // Lookup walks the slots from oldest (head) to newest; a later match
  // overwrites an earlier one so the newest copy of a line wins. The head
  // stays valid until its response, so a line being drained is still found.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    lk_idx = ridx;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = ridx + PW'(k);
      if (valid_q[lk_idx] && (addr_q[lk_idx][ADDR_W-1:4] == q_addr[ADDR_W-1:4])) begin
        q_hit  = 1'b1;
        q_data = data_q[lk_idx];
      end
    end
  end

  // State register. Reset abandons any burst in flight; the memory side is
  // reset together with this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_dcache_wb_buffer
//
// Bench for dcache_wb_buffer. The reference model is a queue of pending
// lines plus two progress markers for the head line (address sent, beats
// sent). Every cycle the monitor compares the DUT against what that queue
// implies: ready/empty from occupancy, lookup from the newest matching queued
// line, burst address/data from the head line, payload stability under
// backpressure, and idle-cycle turnaround. Directed scenarios come first,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_dcache_wb_buffer;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_addr  = '0;
  logic [127:0]      wb_data  = '0;
  logic [ADDR_W-1:0] q_addr   = '0;
  logic              aw_ready = 1'b0;
  logic              w_ready  = 1'b0;
  logic              b_valid  = 1'b0;
  logic              wb_ready, q_hit, aw_valid, w_valid, w_last, b_ready, empty;
  logic [127:0]      q_data;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [31:0]       w_data;

  dcache_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending lines in push order, head at index 0.
  logic [31:0]  m_addr [$];
  logic [127:0] m_data [$];
  bit           m_aw_done = 0;
  int           m_beats   = 0;
  int           b_count   = 0;

  // Handshakes seen at the negedge, applied to the model at the next posedge.
  bit f_push, f_aw, f_w, f_b;
  bit p_aw_hold, p_w_hold, p_after_b, p_idle_nonempty;
  logic [31:0] p_aw_addr, p_w_data;
  logic        p_w_last;
  logic        mon_hit;
  logic [127:0] mon_q;

  logic [31:0] aw_log [$];
  logic [31:0] w_log [$];
  bit          last_log [$];

  bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [31:0] pool [5] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000,
                            32'h0000_4000, 32'h8000_0010};

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Per-cycle comparison against the queue model.
  initial forever begin
    @(negedge clk);
    checkOutput("wb_ready", wb_ready, m_addr.size() < DEPTH);
    checkOutput("empty", empty, m_addr.size() == 0);
    checkOutput("aw_len", aw_len, 8'd3);
    mon_hit = 1'b0;
    mon_q   = '0;
    for (int i = 0; i < m_addr.size(); i++) begin
      if (m_addr[i][31:4] == q_addr[31:4]) begin
        mon_hit = 1'b1;
        mon_q   = m_data[i];
      end
    end
    checkOutput("q_hit", q_hit, mon_hit);
    checkOutput("q_data", q_data, mon_q);
    checkOutput("aw_illegal", aw_valid && !(m_addr.size() > 0 && !m_aw_done), 0);
    checkOutput("w_illegal", w_valid && !(m_addr.size() > 0 && m_aw_done && m_beats < 4), 0);
    checkOutput("b_illegal", b_ready && !(m_addr.size() > 0 && m_beats == 4), 0);
    if (aw_valid && m_addr.size() > 0)
      checkOutput("aw_addr", aw_addr, m_addr[0]);
    if (w_valid && m_addr.size() > 0 && m_beats < 4) begin
      checkOutput("w_data", w_data, m_data[0][32*m_beats +: 32]);
      checkOutput("w_last", w_last, m_beats == 3);
    end
    if (p_aw_hold) begin
      checkOutput("aw_hold_valid", aw_valid, 1);
      checkOutput("aw_hold_addr", aw_addr, p_aw_addr);
    end
    if (p_w_hold) begin
      checkOutput("w_hold_valid", w_valid, 1);
      checkOutput("w_hold_data", w_data, p_w_data);
      checkOutput("w_hold_last", w_last, p_w_last);
    end
    if (p_after_b) checkOutput("turnaround_idle", aw_valid, 0);
    if (p_idle_nonempty) checkOutput("idle_to_aw", aw_valid, 1);
    f_push = wb_valid && wb_ready;
    f_aw   = aw_valid && aw_ready;
    f_w    = w_valid && w_ready;
    f_b    = b_valid && b_ready;
    p_aw_hold = aw_valid && !aw_ready;
    p_aw_addr = aw_addr;
    p_w_hold  = w_valid && !w_ready;
    p_w_data  = w_data;
    p_w_last  = w_last;
    p_after_b = f_b;
    p_idle_nonempty = !aw_valid && !w_valid && !b_ready && (m_addr.size() > 0);
    if (f_aw) aw_log.push_back(aw_addr);
    if (f_w) begin
      w_log.push_back(w_data);
      last_log.push_back(w_last);
    end
  end

  // Model update at the clock edge where the handshakes take effect.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_addr.delete();
      m_data.delete();
      m_aw_done = 0;
      m_beats = 0;
      p_aw_hold = 0;
      p_w_hold = 0;
      p_after_b = 0;
      p_idle_nonempty = 0;
    end else begin
      if (f_push) begin
        m_addr.push_back({wb_addr[31:4], 4'h0});
        m_data.push_back(wb_data);
      end
      if (f_aw) m_aw_done = 1;
      if (f_w) m_beats++;
      if (f_b) begin
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
        m_aw_done = 0;
        m_beats = 0;
        b_count++;
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [127:0] d,
                               input bit awr, input bit wr, input bit bv,
                               input logic [31:0] qa);
    @(posedge clk);
    #1;
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    aw_ready = awr;
    w_ready  = wr;
    b_valid  = bv;
    q_addr   = qa;
  endtask

  task automatic waitDrained(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      applyStimulus(0, '0, '0, 1, 1, 1, q_addr);
      @(negedge clk);
      if (empty) break;
    end
    checkOutput(tag, empty, 1);
  endtask

  task automatic clearLogs();
    aw_log.delete();
    w_log.delete();
    last_log.delete();
  endtask

  task automatic checkBurst(input string pfx, input logic [31:0] a, input logic [127:0] d);
    checkOutput({pfx, "_aw_count"}, aw_log.size(), 1);
    if (aw_log.size() >= 1) checkOutput({pfx, "_aw_addr"}, aw_log[0], a);
    checkOutput({pfx, "_w_count"}, w_log.size(), 4);
    for (int i = 0; i < 4 && i < w_log.size(); i++) begin
      checkOutput({pfx, "_w_word"}, w_log[i], d[32*i +: 32]);
      checkOutput({pfx, "_w_last"}, last_log[i], i == 3);
    end
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_wb_ready"}, wb_ready, 1);
    checkOutput({pfx, "_empty"}, empty, 1);
    checkOutput({pfx, "_aw_valid"}, aw_valid, 0);
    checkOutput({pfx, "_w_valid"}, w_valid, 0);
    checkOutput({pfx, "_b_ready"}, b_ready, 0);
    checkOutput({pfx, "_q_hit"}, q_hit, 0);
    checkOutput({pfx, "_q_data"}, q_data, 0);
    checkOutput({pfx, "_aw_addr"}, aw_addr, 0);
    checkOutput({pfx, "_w_data"}, w_data, 0);
    checkOutput({pfx, "_w_last"}, w_last, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0;
    int pi;
    bit accepted;
    bit wr;
    logic [127:0] d;
    logic [31:0] a;

    // Reset and idle state.
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, 0, 0, 0, 32'h8000_0010);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("init");

    // Single line, memory always ready.
    $display("[TB] single line");
    clearLogs();
    d = 128'h00000044_00000033_00000022_00000011;
    applyStimulus(1, 32'h8000_0010, d, 1, 1, 1, 32'h0);
    waitDrained("single_drain", 40);
    checkBurst("single", 32'h8000_0010, d);

    // Full: two lines with address channel stalled, third must wait for a B.
    $display("[TB] full");
    b0 = b_count;
    applyStimulus(1, 32'h0000_5000, {4{32'h5555_0000}}, 0, 0, 0, 0);
    applyStimulus(1, 32'h0000_6000, {4{32'h6666_0000}}, 0, 0, 0, 0);
    applyStimulus(1, 32'h0000_7000, {4{32'h7777_0000}}, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_wb_ready", wb_ready, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h0000_7000, {4{32'h7777_0000}}, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("full_hold", wb_ready, 0);
    end
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 32'h0000_7000, {4{32'h7777_0000}}, 1, 1, 1, 0);
      @(negedge clk);
      if (wb_ready) begin
        checkOutput("full_accept_after_b", (b_count - b0) >= 1, 1);
        accepted = 1;
        break;
      end
    end
    checkOutput("full_accept", accepted, 1);
    waitDrained("full_drain", 100);

    // Backpressure on the data channel.
    $display("[TB] backpressure");
    clearLogs();
    d = 128'hdddd0003_cccc0002_bbbb0001_aaaa0000;
    applyStimulus(1, 32'h0000_9000, d, 1, 0, 1, 0);
    pi = 0;
    for (int i = 0; i < 60; i++) begin
      wr = (pi < 7) ? pat[pi] : 1'b1;
      applyStimulus(0, '0, '0, 1, wr, 1, 0);
      @(negedge clk);
      if (w_valid) pi++;
      if (empty) break;
    end
    checkOutput("bp_empty", empty, 1);
    checkBurst("bp", 32'h0000_9000, d);

    // Lookup and forwarding.
    $display("[TB] lookup");
    applyStimulus(1, 32'h0000_1000, {4{32'h1111_1111}}, 0, 0, 0, 32'h0000_1008);
    applyStimulus(1, 32'h0000_2000, {4{32'h2222_2222}}, 0, 0, 0, 32'h0000_1008);
    applyStimulus(0, '0, '0, 0, 0, 0, 32'h0000_1008);
    @(negedge clk);
    checkOutput("lk_hit", q_hit, 1);
    checkOutput("lk_data", q_data, {4{32'h1111_1111}});
    b0 = b_count;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, '0, '0, 1, 1, 1, 32'h0000_1008);
      @(negedge clk);
      if (b_count != b0) break;
    end
    checkOutput("lk_gone", q_hit, 0);
    applyStimulus(0, '0, '0, 0, 0, 0, 32'h0000_2004);
    @(negedge clk);
    checkOutput("lk_second_hit", q_hit, 1);
    checkOutput("lk_second_data", q_data, {4{32'h2222_2222}});
    waitDrained("lk_drain", 60);
    applyStimulus(1, 32'h0000_3000, {4{32'h0000_00aa}}, 0, 0, 0, 32'h0000_300c);
    applyStimulus(1, 32'h0000_3004, {4{32'h0000_00bb}}, 0, 0, 0, 32'h0000_300c);
    applyStimulus(0, '0, '0, 0, 0, 0, 32'h0000_3000);
    @(negedge clk);
    checkOutput("dup_hit", q_hit, 1);
    checkOutput("dup_newest", q_data, {4{32'h0000_00bb}});
    waitDrained("dup_drain", 60);

    // Push in the same cycle as the response of the only queued line.
    $display("[TB] simultaneous push/pop");
    applyStimulus(1, 32'h0000_c000, {4{32'hc0c0_c0c0}}, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, '0, '0, 1, 1, 0, 0);
      @(negedge clk);
      if (b_ready) break;
    end
    clearLogs();
    b0 = b_count;
    d = 128'hd4d4d4d4_d3d3d3d3_d2d2d2d2_d1d1d1d1;
    applyStimulus(1, 32'h0000_d000, d, 0, 0, 1, 0);
    applyStimulus(0, '0, '0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("simul_popped", b_count - b0, 1);
    checkOutput("simul_not_empty", empty, 0);
    waitDrained("simul_drain", 60);
    checkBurst("simul", 32'h0000_d000, d);

    // Reset in the middle of a burst.
    $display("[TB] reset mid-burst");
    applyStimulus(1, 32'h0000_a000, {4{32'haaaa_5555}}, 1, 1, 0, 32'h0000_a000);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, '0, '0, 1, 1, 0, 32'h0000_a000);
      @(negedge clk);
      if (w_valid && m_beats == 2) break;
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkResetState("midrst");
    clearLogs();
    d = 128'hf4f4f4f4_f3f3f3f3_f2f2f2f2_f1f1f1f1;
    applyStimulus(1, 32'h0000_b000, d, 1, 1, 1, 0);
    waitDrained("fresh_drain", 40);
    checkBurst("fresh", 32'h0000_b000, d);

    // Randomized traffic against the model, with occasional resets.
    $display("[TB] random phase");
    for (int c = 0; c < 2000; c++) begin
      a = pool[$urandom_range(0, 4)] | 32'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus($urandom_range(0, 1) == 1, a, d,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 7,
                    ($urandom_range(0, 4) == 0) ? $urandom
                                                : (pool[$urandom_range(0, 4)] | 32'($urandom_range(0, 15))));
      rst = ($urandom_range(0, 249) != 0);
    end
    applyStimulus(0, '0, '0, 1, 1, 1, 0);
    rst = 1'b1;
    waitDrained("rand_drain", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
- Write-back drain buffer between the data-cache controller and the memory-side write bus.
- Accepts evicted dirty 128-bit lines that the controller has read out of the dcache line RAM.
- Queues up to DEPTH lines and drains each one as a 4-beat, 32-bit burst: address, then data, then response.
- Offers an address-match lookup so a refill of a line that is still queued is detected and served from the buffer.

Parameters:
- DEPTH, 2, number of queued lines; power of two, 2 or 4.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- wb_valid  in  1  controller presents an evicted line.
- wb_ready  out  1  buffer can accept; equals not-full.
- wb_addr  in  ADDR_W  line base address; bits [3:0] are ignored and stored as 0.
- wb_data  in  128  line data; word0 = [31:0].
- q_addr  in  ADDR_W  lookup address, compared on bits [ADDR_W-1:4].
- q_hit  out  1  combinational; q_addr matches a valid entry.
- q_data  out  128  combinational; data of the matching entry, 0 when no hit.
- aw_valid  out  1  burst address valid.
- aw_ready  in  1  memory accepts the address.
- aw_addr  out  ADDR_W  head-entry address.
- aw_len  out  8  constant 3 (4 beats).
- w_valid  out  1  write data beat valid.
- w_ready  in  1  memory accepts the beat.
- w_data  out  32  current beat word.
- w_last  out  1  high on beat 3.
- b_valid  in  1  write response valid.
- b_ready  out  1  buffer accepts the response.
- empty  out  1  no valid entries; the controller uses it for fence/uncached ordering.

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data}.
  - Write pointer and read pointer are log2(DEPTH)+1 bits; the extra bit distinguishes full from empty.
  - Per-entry valid bit.
- Push: when wb_valid && wb_ready, write the entry at wptr, set its valid bit, and increment wptr (wrap modulo DEPTH).
- Full: wb_ready=0. A wb_valid while full is ignored and the controller holds it.
- Drain FSM, state encoding free: IDLE, AW, W, B.
  - IDLE: if not empty, go to AW next cycle.
  - AW: aw_valid=1 with aw_addr = head addr. Go to W on aw_ready.
  - W: w_valid=1 with w_data = head word[beat]; beat counter runs 0..3.
    - Beat increments on w_ready.
    - w_last = (beat==3).
    - Go to B on w_ready && w_last.
  - B: b_ready=1. On b_valid, clear the head valid bit, increment rptr, reset beat to 0, and go to IDLE.
  - Minimum turnaround: one idle cycle between bursts.
- Valid and data outputs hold steady while their ready is low.
- Simultaneous push and pop in the same cycle: both take effect; occupancy is unchanged.
  - A push is allowed in the same cycle the full FIFO pops only if wb_ready was already high. wb_ready is registered-full based and does not depend on b_valid.
- Lookup:
  - q_hit is the OR of per-entry (valid && addr[ADDR_W-1:4] == q_addr[ADDR_W-1:4]).
  - The entry being drained stays visible until its B handshake completes.
  - On multiple matches, the newest entry wins (the one nearest wptr-1).
- Reset (rst=0 at a clock edge), taking effect at that edge even mid-burst:
  - Pointers become 0, all valid bits clear, FSM goes to IDLE, beat becomes 0.
  - All valid outputs go to 0 and empty=1; wb_ready=1, q_hit=0, q_data=0, aw_addr=0, w_data=0, w_last=0, b_ready=0.
  - Any partial burst is abandoned; the memory side is reset together with this block.

Test Plan:
- Single line: push addr 0x8000_0010, data words {0x44,0x33,0x22,0x11} (word0 = 0x11). With memory always ready:
  - aw_addr=0x8000_0010 and aw_len=3.
  - w_data sequence 0x11, 0x22, 0x33, 0x44, with w_last on the 4th beat.
  - After b_valid: empty=1.
- Full: with DEPTH=2, push 2 lines with aw_ready held 0 -> wb_ready=0. A third wb_valid is not accepted until the first B handshake completes.
- Backpressure: toggle w_ready 1,0,0,1,1,0,1 -> each word is emitted exactly once, in order, and w_data is stable while w_ready=0.
- Lookup and forwarding:
  - Queue 0x1000 and 0x2000; q_addr=0x1008 -> q_hit=1 with q_data = 0x1000 line.
  - After that line's B handshake -> q_hit=0.
  - Duplicate pushes of 0x3000 with different data -> q_data returns the newer data.
- Simultaneous push and pop: FIFO holds 1 entry; push arrives in the same cycle as b_valid -> occupancy stays 1 and the new line drains next with its correct address.
- Reset mid-burst: assert rst=0 during W beat 2 -> next cycle w_valid=0, empty=1, wb_ready=1. A fresh push then drains from beat 0.
